intan_frame_packer: RTL and testbench

//  Upstream stage of the BRAM write FIFO. Packs one Intan SPI frame of 16-bit samples into 64-bit words.

---
 rtl/intan_packer_pkg.sv | 39 +++
 rtl/intan_lane_accumulator.sv | 53 +++++
 rtl/intan_frame_packer.sv | 224 ++++++++++++++++++++++
 tb/tb_intan_frame_packer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intan_packer_pkg.sv
// Shared types, constants and helpers for the Intan frame packer.
//   state_t             : packer FSM states (IDLE, COLLECT, FLUSH, DROP)
//   HEADER_SYNC_DEFAULT : sync pattern placed in header bits [31:16]
//   MASK_*              : contiguous lane masks (lane 0 always lowest bit)
//   frame_words(n)      : words per frame for n channels (header + data words)
//   lane_mask(count)    : contiguous mask for a given number of filled lanes
package intan_packer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [15:0] HEADER_SYNC_DEFAULT = 16'hA5A5;
  localparam int          LANES               = 4;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_1    = 4'b0001;
  localparam logic [3:0] MASK_2    = 4'b0011;
  localparam logic [3:0] MASK_3    = 4'b0111;
  localparam logic [3:0] MASK_4    = 4'b1111;

  function automatic int frame_words(input int n);
    return 1 + (n + LANES - 1) / LANES;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] count);
    case (count)
      3'd0:    return MASK_NONE;
      3'd1:    return MASK_1;
      3'd2:    return MASK_2;
      3'd3:    return MASK_3;
      default: return MASK_4;
    endcase
  endfunction

endpackage

// File: rtl/intan_lane_accumulator.sv
// Fills a 64-bit word with 16-bit samples, lane 0 first.
//   clk, rstn    : clock, asynchronous active-low reset
//   clear        : drop the partial word (end of frame)
//   push, data   : write data into the next free lane
//   word         : current partial word, unused lanes read as zero
//   mask         : contiguous mask of filled lanes
//   empty        : no lanes filled
//   full         : this push fills the last lane; the completed word is on
//                  filled_word and the accumulator restarts empty next cycle
//   filled_word  : partial word with data placed in lane 3
module intan_lane_accumulator
  import intan_packer_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        push,
  input  logic [15:0] data,
  output logic [63:0] word,
  output logic [3:0]  mask,
  output logic        empty,
  output logic        full,
  output logic [63:0] filled_word
);

  logic [2:0] count;

  assign empty       = (count == 3'd0);
  assign full        = push && (count == 3'(LANES - 1));
  assign mask        = lane_mask(count);
  assign filled_word = {data, word[47:0]};

  // A completed word leaves through filled_word, so the register never
  // holds four lanes; it restarts empty instead.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word  <= '0;
      count <= '0;
    end else if (clear || full) begin
      word  <= '0;
      count <= '0;
    end else if (push) begin
      case (count[1:0])
        2'd0:    word[15:0]  <= data;
        2'd1:    word[31:16] <= data;
        2'd2:    word[47:32] <= data;
        default: word[63:48] <= data;
      endcase
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/intan_frame_packer.sv
// Packs one Intan SPI frame of 16-bit samples into 64-bit FIFO words.
// Each frame is a header word {TS, HEADER_SYNC, frame_seq} followed by data
// words with a contiguous lane mask; the last word carries packet_end.
// A frame is written whole or dropped whole, decided at frame_start from the
// downstream headroom.
// Optional feature: define INTAN_PACKER_TIMESTAMP_EN to place a free-running
// clk-cycle counter (latched at frame_start) in header [63:32]; otherwise
// those bits are zero and no counter exists.
// Ports:
//   clk, rstn                : clock, asynchronous active-low reset
//   run                      : accept new frames (looked at only in IDLE)
//   channel_enable           : per-channel keep mask, latched at frame_start
//   frame_start              : 1-cycle frame start pulse
//   sample_valid/data/last   : sample stream, no stall possible
//   fifo_full, fifo_count    : downstream FIFO status
//   fifo_write_en/data/channel_mask/packet_end_flag : registered write port
//   frame_seq                : sequence number of the next frame
//   dropped_frames           : saturating dropped-frame count
//   protocol_error           : sticky protocol violation flag
//   busy                     : FSM not in IDLE
//   fsm_state                : raw FSM state for debug
// Valid/ready: there is no ready on either side. A sample is taken on every
// cycle sample_valid is high; a FIFO word is written on every cycle
// fifo_write_en is high, and headroom is guaranteed before a frame starts.
module intan_frame_packer
  import intan_packer_pkg::*;
#(
  parameter int          NUM_CHANNELS = 32,
  parameter int          FIFO_DEPTH   = 256,
  parameter logic [15:0] HEADER_SYNC  = HEADER_SYNC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    run,
  input  logic [NUM_CHANNELS-1:0] channel_enable,
  input  logic                    frame_start,
  input  logic                    sample_valid,
  input  logic [15:0]             sample_data,
  input  logic                    sample_last,
  input  logic                    fifo_full,
  input  logic [8:0]              fifo_count,
  output logic                    fifo_write_en,
  output logic [63:0]             fifo_write_data,
  output logic [3:0]              fifo_channel_mask,
  output logic                    fifo_packet_end_flag,
  output logic [15:0]             frame_seq,
  output logic [15:0]             dropped_frames,
  output logic                    protocol_error,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  localparam int         FRAME_WORDS  = frame_words(NUM_CHANNELS);
  // Margin of 2 covers our output register and the downstream write latency.
  localparam logic [9:0] HEADROOM_MAX = 10'(FIFO_DEPTH - FRAME_WORDS - 2);
  localparam logic [6:0] CH_LIMIT     = 7'(NUM_CHANNELS);

  state_t                  state, state_next;
  logic [NUM_CHANNELS-1:0] enable_q;
  logic [6:0]              ch_idx;
  logic                    ch_keep;
  logic [63:0]             hold_data;
  logic                    hold_valid;
  logic [31:0]             ts_value;

  logic headroom_ok, start_req, accept, drop, take, last_in;
  logic emit, emit_end, hold_pop;
  logic [63:0] emit_data;
  logic [3:0]  emit_mask;

  logic        acc_clear, acc_empty, acc_full;
  logic [63:0] acc_word, acc_filled;
  logic [3:0]  acc_mask;

`ifdef INTAN_PACKER_TIMESTAMP_EN
  logic [31:0] ts_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ts_count <= '0;
    else       ts_count <= ts_count + 32'd1;
  end

  assign ts_value = ts_count;
`else
  assign ts_value = 32'h0;
`endif

  assign headroom_ok = !fifo_full && ({1'b0, fifo_count} <= HEADROOM_MAX);
  assign start_req   = frame_start && run && (state == IDLE);
  assign accept      = start_req && headroom_ok;
  assign drop        = start_req && !headroom_ok;
  assign last_in     = sample_valid && sample_last;
  assign take        = (state == COLLECT) && sample_valid && ch_keep;
  assign acc_clear   = (state == FLUSH);
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  // Channel lookup by comparison keeps indices past NUM_CHANNELS at zero.
  always_comb begin
    ch_keep = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_idx == 7'(i)) ch_keep = enable_q[i];
    end
  end

  intan_lane_accumulator u_acc (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (acc_clear),
    .push        (take),
    .data        (sample_data),
    .word        (acc_word),
    .mask        (acc_mask),
    .empty       (acc_empty),
    .full        (acc_full),
    .filled_word (acc_filled)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept)    state_next = COLLECT;
        else if (drop) state_next = DROP;
      end
      COLLECT: if (last_in) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      DROP:    if (last_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. The hold word leaves when the accumulator restarts, which
  // is the only cycle a new full word could need the hold slot.
  always_comb begin
    emit      = 1'b0;
    emit_end  = 1'b0;
    emit_data = '0;
    emit_mask = MASK_NONE;
    hold_pop  = 1'b0;
    case (state)
      COLLECT: begin
        if (take && acc_empty && hold_valid) begin
          emit      = 1'b1;
          emit_data = hold_data;
          emit_mask = MASK_4;
          hold_pop  = 1'b1;
        end
      end
      FLUSH: begin
        hold_pop = 1'b1;
        if (!acc_empty) begin
          emit      = 1'b1;
          emit_end  = 1'b1;
          emit_data = acc_word;
          emit_mask = acc_mask;
        end else if (hold_valid) begin
          emit      = 1'b1;
          emit_end  = 1'b1;
          emit_data = hold_data;
          emit_mask = MASK_4;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable_q       <= '0;
      ch_idx         <= '0;
      hold_data      <= '0;
      hold_valid     <= 1'b0;
      frame_seq      <= '0;
      dropped_frames <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (start_req) begin
        enable_q  <= channel_enable;
        frame_seq <= frame_seq + 16'd1;
      end
      if (drop && dropped_frames != 16'hFFFF) dropped_frames <= dropped_frames + 16'd1;

      if (accept) ch_idx <= '0;
      else if (state == COLLECT && sample_valid && ch_idx < CH_LIMIT) ch_idx <= ch_idx + 7'd1;

      if (accept) begin
        hold_data  <= {ts_value, HEADER_SYNC, frame_seq};
        hold_valid <= 1'b1;
      end else if (acc_full) begin
        hold_data  <= acc_filled;
        hold_valid <= 1'b1;
      end else if (hold_pop) begin
        hold_valid <= 1'b0;
      end

      if ((frame_start && state != IDLE) || (sample_valid && state == IDLE))
        protocol_error <= 1'b1;
    end
  end

  // Write port: all four fields registered together; idle cycles read zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_write_en        <= 1'b0;
      fifo_write_data      <= '0;
      fifo_channel_mask    <= '0;
      fifo_packet_end_flag <= 1'b0;
    end else begin
      fifo_write_en        <= emit;
      fifo_write_data      <= emit_data;
      fifo_channel_mask    <= emit_mask;
      fifo_packet_end_flag <= emit_end;
    end
  end

endmodule

// File: tb/tb_intan_frame_packer.sv
// Self-checking bench for intan_frame_packer with NUM_CHANNELS=8.
// A reference model turns each sent frame (enable mask, sample list, headroom
// decision) into the expected word list; a monitor captures written words.
module tb_intan_frame_packer;

  localparam int NCH          = 8;
  localparam int DEPTH        = 256;
  localparam int HEADROOM_MAX = DEPTH - (1 + (NCH + 3) / 4) - 2;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           run = 1'b1;
  logic [NCH-1:0] channel_enable = '0;
  logic           frame_start = 1'b0;
  logic           sample_valid = 1'b0;
  logic [15:0]    sample_data = '0;
  logic           sample_last = 1'b0;
  logic           fifo_full = 1'b0;
  logic [8:0]     fifo_count = '0;
  logic           fifo_write_en;
  logic [63:0]    fifo_write_data;
  logic [3:0]     fifo_channel_mask;
  logic           fifo_packet_end_flag;
  logic [15:0]    frame_seq;
  logic [15:0]    dropped_frames;
  logic           protocol_error;
  logic           busy;
  logic [1:0]     fsm_state;

  // Scoreboard entries are {end, mask, data}.
  logic [68:0] exp_q[$];
  logic [68:0] got_q[$];
  logic [15:0] sent_vals[$];
  logic [15:0] m_seq = '0;
  logic [15:0] m_drop = '0;
  int n_checks = 0;
  int n_err = 0;

  intan_frame_packer #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .run                  (run),
    .channel_enable       (channel_enable),
    .frame_start          (frame_start),
    .sample_valid         (sample_valid),
    .sample_data          (sample_data),
    .sample_last          (sample_last),
    .fifo_full            (fifo_full),
    .fifo_count           (fifo_count),
    .fifo_write_en        (fifo_write_en),
    .fifo_write_data      (fifo_write_data),
    .fifo_channel_mask    (fifo_channel_mask),
    .fifo_packet_end_flag (fifo_packet_end_flag),
    .frame_seq            (frame_seq),
    .dropped_frames       (dropped_frames),
    .protocol_error       (protocol_error),
    .busy                 (busy),
    .fsm_state            (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    frame_start = 1'b0;
    sample_valid = 1'b0;
    sample_last = 1'b0;
    run = 1'b1;
    fifo_full = 1'b0;
    fifo_count = '0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    m_seq = '0;
    m_drop = '0;
    rstn = 1'b1;
  endtask

  // ---------------- monitor ----------------
`ifdef INTAN_PACKER_TIMESTAMP_EN
  bit at_hdr = 1'b1;
`endif

  always @(negedge clk) begin
    logic [63:0] d;
    if (rstn && fifo_write_en) begin
      d = fifo_write_data;
`ifdef INTAN_PACKER_TIMESTAMP_EN
      if (at_hdr) d[63:32] = 32'h0;
      at_hdr = fifo_packet_end_flag;
`endif
      got_q.push_back({fifo_packet_end_flag, fifo_channel_mask, d});
    end
`ifdef INTAN_PACKER_TIMESTAMP_EN
    if (!rstn) at_hdr = 1'b1;
`endif
  end

  // ---------------- reference model ----------------
  // Kept samples are the enabled ones among the first NCH; they are packed
  // four per word after a header, and the frame's final word carries end=1.
  task automatic model_frame(input logic [NCH-1:0] en, input bit accept);
    logic [15:0] kept[$];
    logic [63:0] data;
    int n, nw, cnt;
    if (!accept) begin
      if (m_drop != 16'hFFFF) m_drop++;
      m_seq++;
      return;
    end
    for (int i = 0; i < sent_vals.size() && i < NCH; i++)
      if (en[i]) kept.push_back(sent_vals[i]);
    n  = kept.size();
    nw = (n + 3) / 4;
    exp_q.push_back({(nw == 0), 4'hF, 32'h0, 16'hA5A5, m_seq});
    for (int w = 0; w < nw; w++) begin
      data = '0;
      cnt  = 0;
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < n) begin
          data[16*l +: 16] = kept[4*w+l];
          cnt++;
        end
      end
      exp_q.push_back({(w == nw - 1), 4'((1 << cnt) - 1), data});
    end
    m_seq++;
  endtask

  // ---------------- drivers ----------------
  // mid_event: 0 none, 1 deassert run after frame_start, 2 frame_start pulse
  // alongside the second sample.
  task automatic send_frame(input logic [NCH-1:0] en, input int nsamp, input bit directed,
                            input bit gaps, input int mid_event);
    bit accept;
    sent_vals.delete();
    @(negedge clk);
    channel_enable = en;
    frame_start = 1'b1;
    accept = !fifo_full && (int'(fifo_count) <= HEADROOM_MAX);
    @(negedge clk);
    frame_start = 1'b0;
    channel_enable = NCH'($urandom);
    if (mid_event == 1) run = 1'b0;
    for (int i = 0; i < nsamp; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = directed ? 16'(i + 1) : 16'($urandom);
      sample_last  = (i == nsamp - 1);
      frame_start  = (mid_event == 2 && i == 1);
      sent_vals.push_back(sample_data);
      @(negedge clk);
      sample_valid = 1'b0;
      sample_last  = 1'b0;
      frame_start  = 1'b0;
    end
    run = 1'b1;
    model_frame(en, accept);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 64) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (fifo_write_en !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", fifo_write_en); end
    if (fifo_write_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", fifo_write_data); end
    if (frame_seq !== 16'h0) begin n_err++; $display("FAIL reset_seq: got %h expected 0", frame_seq); end
    if (dropped_frames !== 16'h0) begin n_err++; $display("FAIL reset_drop: got %h expected 0", dropped_frames); end
    if (protocol_error !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b expected 0", protocol_error); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({fifo_channel_mask, fifo_packet_end_flag, busy} !== 6'h0) begin
      n_err++; $display("FAIL reset_release: got %h expected 0", {fifo_channel_mask, fifo_packet_end_flag, busy});
    end
  endtask

  task automatic test_basic_frames();
    send_frame(8'hFF, 8, 1'b1, 1'b0, 0);
    send_frame(8'h07, 8, 1'b1, 1'b0, 0);
    send_frame(8'h00, 8, 1'b1, 1'b0, 0);
    send_frame(8'h1F, 8, 1'b1, 1'b1, 0);
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    n_checks++;
    if (frame_seq !== m_seq) begin n_err++; $display("FAIL basic_seq: got %0d expected %0d", frame_seq, m_seq); end
  endtask

  task automatic test_drop_headroom();
    fifo_count = 9'(DEPTH - 1);
    send_frame(8'hFF, 8, 1'b1, 1'b0, 0);
    fifo_count = 9'(HEADROOM_MAX + 1);
    send_frame(8'h0F, 5, 1'b0, 1'b0, 0);
    fifo_count = 9'(HEADROOM_MAX);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 0);
    fifo_count = 9'd0; fifo_full = 1'b1;
    send_frame(8'hFF, 8, 1'b0, 1'b0, 0);
    fifo_full = 1'b0;
    send_frame(8'hFF, 8, 1'b1, 1'b0, 0);
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL drop_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL drop_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    n_checks += 2;
    if (dropped_frames !== m_drop) begin n_err++; $display("FAIL drop_cnt: got %0d expected %0d", dropped_frames, m_drop); end
    if (frame_seq !== m_seq) begin n_err++; $display("FAIL drop_seq: got %0d expected %0d", frame_seq, m_seq); end
  endtask

  task automatic test_run_control();
    @(negedge clk);
    run = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 2;
    if (frame_seq !== m_seq) begin n_err++; $display("FAIL run_off_seq: got %0d expected %0d", frame_seq, m_seq); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL run_off_busy: got %b expected 0", busy); end
    send_frame(8'hF3, 8, 1'b0, 1'b1, 1);
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL run_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL run_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) send_frame(NCH'($urandom), 8, 1'b0, 1'b0, 0);
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      fifo_count = 9'($urandom_range(HEADROOM_MAX - 6, DEPTH - 1));
      fifo_full  = ($urandom_range(0, 7) == 0);
      send_frame(NCH'($urandom), $urandom_range(1, 11), 1'b0, 1'b1, 0);
    end
    fifo_count = '0;
    fifo_full = 1'b0;
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    n_checks += 3;
    if (frame_seq !== m_seq) begin n_err++; $display("FAIL rand_seq: got %0d expected %0d", frame_seq, m_seq); end
    if (dropped_frames !== m_drop) begin n_err++; $display("FAIL rand_drop: got %0d expected %0d", dropped_frames, m_drop); end
    if (protocol_error !== 1'b0) begin n_err++; $display("FAIL rand_perr: got %b expected 0", protocol_error); end
  endtask

  task automatic test_protocol_error();
    do_reset();
    @(negedge clk);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (protocol_error !== 1'b1) begin n_err++; $display("FAIL perr_idle_sample: got %b expected 1", protocol_error); end
    do_reset();
    send_frame(8'hFF, 8, 1'b1, 1'b0, 2);
    wait_drain();
    n_checks += 2;
    if (protocol_error !== 1'b1) begin n_err++; $display("FAIL perr_restart: got %b expected 1", protocol_error); end
    if (frame_seq !== m_seq) begin n_err++; $display("FAIL perr_seq: got %0d expected %0d", frame_seq, m_seq); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL perr_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL perr_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    channel_enable = 8'hFF;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    sample_valid = 1'b1;
    sample_data = 16'h1234;
    @(negedge clk);
    sample_valid = 1'b0;
    n_checks += 2;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    if (fifo_write_en !== 1'b1) begin n_err++; $display("FAIL midrst_hdr_write: got %b expected 1", fifo_write_en); end
    rstn = 1'b0;
    #1;
    n_checks += 4;
    if (fifo_write_en !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %b expected 0", fifo_write_en); end
    if (fifo_write_data !== 64'h0) begin n_err++; $display("FAIL midrst_data: got %h expected 0", fifo_write_data); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (frame_seq !== 16'h0) begin n_err++; $display("FAIL midrst_seq: got %h expected 0", frame_seq); end
    @(negedge clk);
    exp_q.delete(); got_q.delete();
    m_seq = '0; m_drop = '0;
    rstn = 1'b1;
    send_frame(8'hFF, 8, 1'b1, 1'b0, 0);
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL midrst_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_drop_headroom();
    test_run_control();
    test_back_to_back();
    test_random();
    test_protocol_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
